// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: NOP encoding, default reset PC,
// fetch FSM states and the instruction-queue entry payload.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RV_NOP           = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order circular FIFO of fetched {instruction, pc} entries.
// Ports: push/push_data write the tail, pop retires the head (ignored when
// empty), flush empties the queue and wins over push/pop.
// count = occupancy, head = oldest entry, full = count == DEPTH.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  fetch_entry_t                  push_data,
  input  logic                          pop,
  input  logic                          flush,
  output logic [$clog2(DEPTH):0]        count,
  output fetch_entry_t                  head,
  output logic                          full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  // Pointer/count update; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  // The issue credit rule guarantees a free slot for every response.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !flush && full))
        else $error("fetch_queue overflow");
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word requests to imem,
// buffers responses in fetch_queue and presents the head to decode.
// Ports: imem_req_* (registered request, held until accepted),
// imem_resp_* (in-order responses, no backpressure), redirect_* (flush and
// retarget from execute), id_* (queue head to decode, NOP when empty).
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned     QUEUE_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instruction,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  fetch_state_e     state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [XLEN-1:0]  req_addr_q, req_addr_d;
  logic             req_valid_q, req_valid_d;
  logic             pend_stale_q, pend_stale_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] stale_q, stale_d;

  logic [CNT_W-1:0] q_count, q_count_d;
  fetch_entry_t     q_head, q_push_data;
  logic             q_full, q_push, q_flush;
  logic             req_fire, id_pop, resp_drop;
  logic [XLEN-1:0]  redirect_base;
  logic             unused_ok;

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (id_pop),
    .flush     (q_flush),
    .count     (q_count),
    .head      (q_head),
    .full      (q_full)
  );

  // Next-state, request issue, response routing and redirect handling.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    req_addr_d    = req_addr_q;
    req_valid_d   = req_valid_q;
    pend_stale_d  = pend_stale_q;
    stale_d       = stale_q;
    q_push        = 1'b0;
    q_flush       = 1'b0;
    resp_drop     = 1'b0;
    q_push_data   = '{instr: imem_resp_data, pc: resp_pc_q};
    req_fire      = req_valid_q && imem_req_ready;
    id_pop        = (q_count != '0) && id_ready;
    redirect_base = {redirect_pc[XLEN-1:2], 2'b00};

    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);

    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path;
      // a request still waiting for ready is tracked separately until it fires.
      q_flush      = 1'b1;
      fetch_pc_d   = redirect_base;
      resp_pc_d    = redirect_base;
      stale_d      = outstanding_d;
      pend_stale_d = req_valid_q && !imem_req_ready;
    end else begin
      resp_drop = imem_resp_valid && (stale_q != '0);
      if (imem_resp_valid && (stale_q == '0)) begin
        q_push    = 1'b1;
        resp_pc_d = resp_pc_q + 32'd4;
      end
      stale_d = stale_q - CNT_W'(resp_drop) + CNT_W'(req_fire && pend_stale_q);
      if (req_fire) pend_stale_d = 1'b0;
    end

    q_count_d = q_count;
    if (q_flush) begin
      q_count_d = '0;
    end else begin
      case ({q_push, id_pop})
        2'b10:   q_count_d = q_count + CNT_W'(1);
        2'b01:   q_count_d = q_count - CNT_W'(1);
        default: q_count_d = q_count;
      endcase
    end

    if (state_q == BOOT) begin
      state_d = RUN;
    end else if ((stale_d != '0) || pend_stale_d) begin
      state_d = DRAIN;
    end else begin
      state_d = RUN;
    end

    // A presented request is held until accepted; otherwise load the next one
    // if the queue will still have room for every fetch in flight.
    if (req_valid_q && !req_fire) begin
      req_valid_d = 1'b1;
    end else if ((state_d == RUN) &&
                 ((SUM_W'(q_count_d) + SUM_W'(outstanding_d)) < SUM_W'(QUEUE_DEPTH))) begin
      req_valid_d = 1'b1;
      req_addr_d  = fetch_pc_d;
      fetch_pc_d  = fetch_pc_d + 32'd4;
    end else begin
      req_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      req_addr_q    <= RESET_PC;
      req_valid_q   <= 1'b0;
      pend_stale_q  <= 1'b0;
      outstanding_q <= '0;
      stale_q       <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      req_addr_q    <= req_addr_d;
      req_valid_q   <= req_valid_d;
      pend_stale_q  <= pend_stale_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;

  // Decode sees the head directly; when empty it sees a NOP at the next PC.
  assign id_valid       = (q_count != '0);
  assign id_instruction = id_valid ? q_head.instr : RV_NOP;
  assign id_pc          = id_valid ? q_head.pc : resp_pc_q;
  assign id_pc_plus4    = id_pc + 32'd4;

  assign unused_ok = ^{redirect_pc[1:0], q_full};

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 1;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] fire_log[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_ins[$];

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instruction  (id_instruction),
    .id_pc           (id_pc),
    .id_pc_plus4     (id_pc_plus4)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hABCD_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Fixed-latency instruction memory, responses launched just after the edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    imem_resp_valid = 1'b0;
    if (!rst_n) begin
      pend_addr.delete();
      pend_due.delete();
    end else if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
  end

  // Log accepted requests and delivered instructions.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req_valid && imem_req_ready) begin
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(cyc + mem_lat);
        fire_log.push_back(imem_req_addr);
      end
      if (id_valid && id_ready) begin
        got_pc.push_back(id_pc);
        got_ins.push_back(id_instruction);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int lat);
    rst_n          = 1'b0;
    mem_lat        = lat;
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    fire_log.delete();
    got_pc.delete();
    got_ins.delete();
    rst_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check_eq({tag, "_req_addr"}, imem_req_addr, 32'h0);
    check_eq({tag, "_id_valid"}, 32'(id_valid), 32'd0);
    check_eq({tag, "_id_instr"}, id_instruction, 32'h0000_0013);
    check_eq({tag, "_id_pc"}, id_pc, 32'h0);
    check_eq({tag, "_id_pc4"}, id_pc_plus4, 32'h4);
  endtask

  task automatic wait_deliveries(input string tag, input int n);
    int k = 0;
    while (got_pc.size() < n && k < 200) begin
      at_neg();
      k++;
    end
    check_eq({tag, "_delivered"}, 32'(got_pc.size() >= n), 32'd1);
  endtask

  task automatic verify_stream(input string tag, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      if (i < got_pc.size()) begin
        check_eq($sformatf("%s_pc%0d", tag, i), got_pc[i], base + 32'(4 * i));
        check_eq($sformatf("%s_ins%0d", tag, i), got_ins[i], mem_word(base + 32'(4 * i)));
      end
    end
  endtask

  task automatic wait_req(input string tag, input logic [31:0] addr);
    int k = 0;
    at_neg();
    while (!(imem_req_valid && imem_req_addr == addr) && k < 20) begin
      at_neg();
      k++;
    end
    check_eq(tag, 32'(imem_req_valid && imem_req_addr == addr), 32'd1);
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    at_neg();
    check_reset_vals("rst");

    // Basic streaming, 1-cycle memory
    do_reset(1);
    at_neg();
    check_eq("boot_no_req", 32'(imem_req_valid), 32'd0);
    at_neg();
    check_eq("c1_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("c1_req_addr", imem_req_addr, 32'h0);
    at_neg();
    check_eq("c2_req_addr", imem_req_addr, 32'h4);
    check_eq("c2_id_valid", 32'(id_valid), 32'd0);
    at_neg();
    check_eq("c3_id_valid", 32'(id_valid), 32'd1);
    check_eq("c3_id_pc", id_pc, 32'h0);
    check_eq("c3_id_instr", id_instruction, 32'hABCD_0000);
    check_eq("c3_id_pc4", id_pc_plus4, 32'h4);
    check_eq("c3_credit_stall", 32'(imem_req_valid), 32'd0);
    wait_deliveries("s1", 4);
    verify_stream("s1", 32'h0, 4);
    check_eq("s1_fire2", (fire_log.size() > 2) ? fire_log[2] : 32'hFFFF_FFFF, 32'h8);

    // Decode stall: at most two fetches, head holds
    do_reset(1);
    id_ready = 1'b0;
    repeat (6) at_neg();
    check_eq("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("stall_fires", 32'(fire_log.size()), 32'd2);
    check_eq("stall_id_valid", 32'(id_valid), 32'd1);
    check_eq("stall_id_pc", id_pc, 32'h0);
    check_eq("stall_id_instr", id_instruction, 32'hABCD_0000);
    step();
    id_ready = 1'b1;
    wait_deliveries("s2", 5);
    verify_stream("s2", 32'h0, 5);

    // imem backpressure holds the request
    do_reset(1);
    wait_req("bp_see4", 32'h4);
    step();
    imem_req_ready = 1'b0;
    wait_req("bp_see8", 32'h8);
    at_neg();
    check_eq("bp_hold1", 32'(imem_req_valid && imem_req_addr == 32'h8), 32'd1);
    at_neg();
    check_eq("bp_hold2", 32'(imem_req_valid && imem_req_addr == 32'h8), 32'd1);
    check_eq("bp_not_fired", 32'(fire_log.size()), 32'd2);
    step();
    imem_req_ready = 1'b1;
    wait_deliveries("s3", 5);
    verify_stream("s3", 32'h0, 5);

    // Redirect with two responses outstanding, 3-cycle memory
    do_reset(3);
    begin
      int k = 0;
      while (fire_log.size() < 2 && k < 20) begin
        at_neg();
        k++;
      end
    end
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    at_neg();
    check_eq("rd4_id_valid", 32'(id_valid), 32'd0);
    wait_deliveries("s4", 3);
    verify_stream("s4", 32'h100, 3);
    check_eq("rd4_fire2", (fire_log.size() > 2) ? fire_log[2] : 32'hFFFF_FFFF, 32'h100);

    // Redirect coinciding with a response and a request fire
    do_reset(1);
    begin
      int k = 0;
      at_neg();
      while (!(imem_req_valid && imem_req_ready && imem_resp_valid) && k < 20) begin
        at_neg();
        k++;
      end
      check_eq("rd5_found", 32'(imem_req_valid && imem_req_ready && imem_resp_valid), 32'd1);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    step();
    redirect_valid = 1'b0;
    wait_deliveries("s5", 3);
    verify_stream("s5", 32'h300, 3);
    check_eq("rd5_fire2", (fire_log.size() > 2) ? fire_log[2] : 32'hFFFF_FFFF, 32'h300);

    // Redirect to unaligned target with a full queue
    step();
    id_ready = 1'b0;
    repeat (6) at_neg();
    check_eq("rd6_full_valid", 32'(id_valid), 32'd1);
    step();
    got_pc.delete();
    got_ins.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    step();
    redirect_valid = 1'b0;
    at_neg();
    check_eq("rd6_id_valid", 32'(id_valid), 32'd0);
    check_eq("rd6_id_instr", id_instruction, 32'h0000_0013);
    check_eq("rd6_req_addr", imem_req_addr, 32'h200);
    check_eq("rd6_req_valid", 32'(imem_req_valid), 32'd1);
    begin
      int k = 0;
      while (!id_valid && k < 20) begin
        at_neg();
        k++;
      end
    end
    check_eq("rd6_head_pc", id_pc, 32'h200);
    check_eq("rd6_head_pc4", id_pc_plus4, 32'h204);
    check_eq("rd6_head_instr", id_instruction, 32'hABCD_0200);
    step();
    id_ready = 1'b1;
    wait_deliveries("s6", 3);
    verify_stream("s6", 32'h200, 3);

    // Asynchronous reset mid-stream
    at_neg();
    rst_n = 1'b0;
    #1;
    check_reset_vals("async");
    do_reset(1);
    wait_deliveries("s7", 2);
    verify_stream("s7", 32'h0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
